// File: rtl/bu_redirect_ctl.sv
// bu_redirect_ctl: sits downstream of the branch unit. It detects PC redirects
// (fetch always predicts pc+4), flushes the back end for a fixed number of
// cycles, then offers the corrected PC to fetch over a valid/ready handshake.
// It also owns the architectural privilege level, a sticky fault flag for
// illegal user jumps into the supervisor region, and a saturating mispredict
// counter.
module bu_redirect_ctl #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    FLUSH_CYCLES = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = {DATA_WIDTH{1'b0}},
    parameter logic [DATA_WIDTH-1:0] PRIV_START   = DATA_WIDTH'(64'h0000_0000_8000_0000),
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  retire_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    input  logic [DATA_WIDTH-1:0] result_pc_i,
    input  logic                  result_pc_vld_i,
    input  logic                  is_ecall_i,
    input  logic                  is_eret_i,
    input  logic                  fetch_ready_i,
    output logic                  flush_o,
    output logic                  fetch_stall_o,
    output logic                  redirect_vld_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic                  cpl_o,
    output logic                  fault_o,
    output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic CPL_USER = 1'b0;
    localparam logic CPL_SUPV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1);
        end
    endfunction

    state_t                r_state;
    state_t                w_next_state;
    logic [FC_W-1:0]       r_flush_cnt;
    logic [DATA_WIDTH-1:0] r_tgt;
    logic                  r_cpl;
    logic                  r_fault;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_flush;
    logic                  r_stall;
    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_pc;

    logic                  w_flush_nxt;
    logic                  w_stall_nxt;
    logic                  w_vld_nxt;
    logic [DATA_WIDTH-1:0] w_pc_nxt;

    // Only a retire seen in IDLE is architecturally meaningful; anything
    // retiring while the back end is being flushed is dropped.
    logic                  w_retire_idle;
    logic                  w_ctrl;
    logic [DATA_WIDTH-1:0] w_seq_pc;
    logic                  w_fault;
    logic                  w_redirect;

    assign w_retire_idle = retire_i && (r_state == ST_IDLE);
    assign w_ctrl        = w_retire_idle && result_pc_vld_i;
    assign w_seq_pc      = pc_i + DATA_WIDTH'(4);
    // Fault wins over redirect; ECALL is the legal way into supervisor code.
    assign w_fault       = w_ctrl && (r_cpl == CPL_USER) && !is_ecall_i &&
                           (result_pc_i >= PRIV_START);
    assign w_redirect    = w_ctrl && !w_fault &&
                           ((result_pc_i != w_seq_pc) || is_ecall_i || is_eret_i);

    // Next-state decision for the redirect sequencer.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fault) begin
                    w_next_state = ST_HALT;
                end else if (w_redirect) begin
                    w_next_state = ST_FLUSH;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (r_flush_cnt == FC_W'(0)) begin
                    w_next_state = ST_REDIRECT;
                end else begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_REDIRECT: begin
                if (fetch_ready_i) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_REDIRECT;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_HALT;
            end
        endcase
    end

    // Output decode from the next state so the outputs can be registered
    // and still line up with the state they describe.
    always_comb begin
        w_flush_nxt = 1'b0;
        w_stall_nxt = 1'b0;
        w_vld_nxt   = 1'b0;
        w_pc_nxt    = {DATA_WIDTH{1'b0}};
        case (w_next_state)
            ST_IDLE: begin
                w_flush_nxt = 1'b0;
            end
            ST_FLUSH: begin
                w_flush_nxt = 1'b1;
                w_stall_nxt = 1'b1;
            end
            ST_REDIRECT: begin
                w_stall_nxt = 1'b1;
                w_vld_nxt   = 1'b1;
                // Target is always latched on the IDLE->FLUSH edge, before
                // REDIRECT can be entered, so r_tgt is already final here.
                w_pc_nxt    = (w_redirect) ? result_pc_i : r_tgt;
            end
            ST_HALT: begin
                w_flush_nxt = 1'b1;
                w_stall_nxt = 1'b1;
            end
            default: begin
                w_flush_nxt = 1'b1;
                w_stall_nxt = 1'b1;
            end
        endcase
    end

    // State register and registered outputs; reset restarts fetch at RESET_PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_REDIRECT;
            r_flush <= 1'b0;
            r_stall <= 1'b1;
            r_vld   <= 1'b1;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_flush <= w_flush_nxt;
            r_stall <= w_stall_nxt;
            r_vld   <= w_vld_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Datapath state: target latch, flush countdown, privilege, fault, counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tgt       <= RESET_PC;
            r_flush_cnt <= FC_W'(0);
            r_cpl       <= CPL_SUPV;
            r_fault     <= 1'b0;
            r_cnt       <= {CNT_WIDTH{1'b0}};
        end else begin
            if (w_redirect) begin
                r_tgt       <= result_pc_i;
                r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                r_cnt       <= sat_inc(r_cnt);
            end else if ((r_state == ST_FLUSH) && (r_flush_cnt != FC_W'(0))) begin
                r_flush_cnt <= r_flush_cnt - FC_W'(1);
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
            // ECALL takes precedence when both privilege flags are set.
            if (w_retire_idle && is_ecall_i) begin
                r_cpl <= CPL_SUPV;
            end else if (w_retire_idle && is_eret_i) begin
                r_cpl <= CPL_USER;
            end else begin
                r_cpl <= r_cpl;
            end
            if (w_fault) begin
                r_fault <= 1'b1;
            end else begin
                r_fault <= r_fault;
            end
        end
    end

    assign flush_o          = r_flush;
    assign fetch_stall_o    = r_stall;
    assign redirect_vld_o   = r_vld;
    assign redirect_pc_o    = r_pc;
    assign cpl_o            = r_cpl;
    assign fault_o          = r_fault;
    assign mispredict_cnt_o = r_cnt;

endmodule

// File: tb/tb_bu_redirect_ctl.sv
// Testbench for bu_redirect_ctl: scenario tasks with inline checks plus a
// scoreboard of expected redirect PCs consumed at each fetch handshake.
module tb_bu_redirect_ctl;

    localparam logic [63:0] RPC  = 64'h0000_0000_0000_1000;
    localparam logic [63:0] PRIV = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        retire_i = 1'b0;
    logic [63:0] pc_i = 64'h0;
    logic [63:0] result_pc_i = 64'h0;
    logic        result_pc_vld_i = 1'b0;
    logic        is_ecall_i = 1'b0;
    logic        is_eret_i = 1'b0;
    logic        fetch_ready_i = 1'b0;

    logic        flush_o, fetch_stall_o, redirect_vld_o, cpl_o, fault_o;
    logic [63:0] redirect_pc_o;
    logic [31:0] cnt_o;
    logic        flush2, stall2, vld2, cpl2, fault2;
    logic [63:0] pc2;
    logic [1:0]  cnt2;

    int checks = 0;
    int failures = 0;
    int exp_cnt = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    bu_redirect_ctl #(.DATA_WIDTH(64), .FLUSH_CYCLES(2), .RESET_PC(RPC),
                      .PRIV_START(PRIV), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .retire_i(retire_i), .pc_i(pc_i),
        .result_pc_i(result_pc_i), .result_pc_vld_i(result_pc_vld_i),
        .is_ecall_i(is_ecall_i), .is_eret_i(is_eret_i), .fetch_ready_i(fetch_ready_i),
        .flush_o(flush_o), .fetch_stall_o(fetch_stall_o), .redirect_vld_o(redirect_vld_o),
        .redirect_pc_o(redirect_pc_o), .cpl_o(cpl_o), .fault_o(fault_o),
        .mispredict_cnt_o(cnt_o));

    bu_redirect_ctl #(.DATA_WIDTH(64), .FLUSH_CYCLES(2), .RESET_PC(RPC),
                      .PRIV_START(PRIV), .CNT_WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .retire_i(retire_i), .pc_i(pc_i),
        .result_pc_i(result_pc_i), .result_pc_vld_i(result_pc_vld_i),
        .is_ecall_i(is_ecall_i), .is_eret_i(is_eret_i), .fetch_ready_i(fetch_ready_i),
        .flush_o(flush2), .fetch_stall_o(stall2), .redirect_vld_o(vld2),
        .redirect_pc_o(pc2), .cpl_o(cpl2), .fault_o(fault2),
        .mispredict_cnt_o(cnt2));

    // Scoreboard: every accepted redirect must match the oldest expected PC.
    always @(negedge clk) begin
        if (!rst && redirect_vld_o === 1'b1 && fetch_ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got redirect pc=%h, expected none", redirect_pc_o);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (redirect_pc_o !== e) begin
                    failures++;
                    $display("FAIL sb_pc: got %h expected %h", redirect_pc_o, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fetch_ready_i = 1'b0;
        retire_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(RPC);
        exp_cnt = 0;
    endtask

    task automatic do_retire(input logic [63:0] pc, input logic [63:0] tgt,
                             input logic ec, input logic er);
        pc_i = pc; result_pc_i = tgt; result_pc_vld_i = 1'b1;
        is_ecall_i = ec; is_eret_i = er; retire_i = 1'b1;
        tick();
        retire_i = 1'b0; is_ecall_i = 1'b0; is_eret_i = 1'b0; result_pc_vld_i = 1'b0;
    endtask

    task automatic finish_redirect();
        bit seen = 1'b0;
        fetch_ready_i = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (redirect_vld_o === 1'b1) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL redirect_timeout: redirect_vld_o=%b expected 1", redirect_vld_o);
        end
        tick();
        checks++;
        if (redirect_vld_o !== 1'b0 || fetch_stall_o !== 1'b0) begin
            failures++;
            $display("FAIL post_transfer_idle: vld=%b stall=%b expected 0 0", redirect_vld_o, fetch_stall_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({redirect_vld_o, fetch_stall_o, flush_o, cpl_o, fault_o} !== 5'b11010 ||
            redirect_pc_o !== RPC || cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: vld/stall/flush/cpl/fault=%b%b%b%b%b pc=%h cnt=%0d expected 11010 %h 0",
                     redirect_vld_o, fetch_stall_o, flush_o, cpl_o, fault_o, redirect_pc_o, cnt_o, RPC);
        end
        fetch_ready_i = 1'b1;
        tick();
        checks++;
        if ({redirect_vld_o, fetch_stall_o, flush_o, cpl_o} !== 4'b0001 || redirect_pc_o !== 64'h0) begin
            failures++;
            $display("FAIL reset_idle: vld/stall/flush/cpl=%b%b%b%b pc=%h expected 0001 0",
                     redirect_vld_o, fetch_stall_o, flush_o, cpl_o, redirect_pc_o);
        end
    endtask

    task automatic test_basic();
        do_retire(64'h100, 64'h104, 1'b0, 1'b0);
        checks++;
        if (flush_o !== 1'b0 || fetch_stall_o !== 1'b0 || cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL seq_no_flush: flush=%b stall=%b cnt=%0d expected 0 0 0", flush_o, fetch_stall_o, cnt_o);
        end
        do_retire(64'h100, 64'h200, 1'b0, 1'b0);
        exp_q.push_back(64'h200); exp_cnt++;
        checks++;
        if (flush_o !== 1'b1 || redirect_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_n1: flush=%b vld=%b expected 1 0", flush_o, redirect_vld_o);
        end
        tick();
        checks++;
        if (flush_o !== 1'b1 || redirect_vld_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_n2: flush=%b vld=%b expected 1 0", flush_o, redirect_vld_o);
        end
        tick();
        checks++;
        if (flush_o !== 1'b0 || redirect_vld_o !== 1'b1 || redirect_pc_o !== 64'h200 || cnt_o !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL redirect_n3: flush=%b vld=%b pc=%h cnt=%0d expected 0 1 200 %0d",
                     flush_o, redirect_vld_o, redirect_pc_o, cnt_o, exp_cnt);
        end
        finish_redirect();
    endtask

    task automatic test_backpressure();
        fetch_ready_i = 1'b0;
        do_retire(64'h300, 64'h400, 1'b0, 1'b0);
        exp_q.push_back(64'h400); exp_cnt++;
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (redirect_vld_o !== 1'b1 || redirect_pc_o !== 64'h400) begin
                failures++;
                $display("FAIL hold_%0d: vld=%b pc=%h expected 1 400", i, redirect_vld_o, redirect_pc_o);
            end
            tick();
        end
        finish_redirect();
        checks++;
        if (cnt_o !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL bp_count: got %0d expected %0d", cnt_o, exp_cnt);
        end
    endtask

    task automatic test_priv();
        do_retire(64'h500, 64'h600, 1'b0, 1'b1);
        exp_q.push_back(64'h600); exp_cnt++;
        checks++;
        if (cpl_o !== 1'b0) begin
            failures++;
            $display("FAIL eret_cpl: got %b expected 0", cpl_o);
        end
        finish_redirect();
        do_retire(64'h700, PRIV + 64'h100, 1'b1, 1'b0);
        exp_q.push_back(PRIV + 64'h100); exp_cnt++;
        checks++;
        if (cpl_o !== 1'b1 || fault_o !== 1'b0 || flush_o !== 1'b1) begin
            failures++;
            $display("FAIL ecall_user: cpl=%b fault=%b flush=%b expected 1 0 1", cpl_o, fault_o, flush_o);
        end
        finish_redirect();
        do_retire(64'h800, 64'h900, 1'b1, 1'b1);
        exp_q.push_back(64'h900); exp_cnt++;
        checks++;
        if (cpl_o !== 1'b1) begin
            failures++;
            $display("FAIL both_ecall_eret: cpl=%b expected 1", cpl_o);
        end
        finish_redirect();
        do_retire(64'h880, 64'h900, 1'b0, 1'b1);
        exp_q.push_back(64'h900); exp_cnt++;
        finish_redirect();
        do_retire(64'hA00, PRIV - 64'h4, 1'b0, 1'b0);
        exp_q.push_back(PRIV - 64'h4); exp_cnt++;
        checks++;
        if (fault_o !== 1'b0 || flush_o !== 1'b1) begin
            failures++;
            $display("FAIL below_priv: fault=%b flush=%b expected 0 1", fault_o, flush_o);
        end
        finish_redirect();
        do_retire(64'hA00, PRIV, 1'b0, 1'b0);
        checks++;
        if ({fault_o, flush_o, fetch_stall_o, redirect_vld_o} !== 4'b1110 || cnt_o !== 32'(exp_cnt)) begin
            failures++;
            $display("FAIL fault_halt: fault/flush/stall/vld=%b%b%b%b cnt=%0d expected 1110 %0d",
                     fault_o, flush_o, fetch_stall_o, redirect_vld_o, cnt_o, exp_cnt);
        end
        do_retire(64'hB00, 64'h10, 1'b1, 1'b0);
        tick(); tick();
        checks++;
        if ({fault_o, flush_o, redirect_vld_o, cpl_o} !== 4'b1100) begin
            failures++;
            $display("FAIL halt_sticky: fault/flush/vld/cpl=%b%b%b%b expected 1100",
                     fault_o, flush_o, redirect_vld_o, cpl_o);
        end
        do_reset();
        checks++;
        if (fault_o !== 1'b0 || cpl_o !== 1'b1 || redirect_vld_o !== 1'b1) begin
            failures++;
            $display("FAIL halt_reset: fault=%b cpl=%b vld=%b expected 0 1 1", fault_o, cpl_o, redirect_vld_o);
        end
        finish_redirect();
    endtask

    task automatic test_ignored();
        fetch_ready_i = 1'b0;
        do_retire(64'h100, 64'h300, 1'b0, 1'b0);
        exp_q.push_back(64'h300); exp_cnt++;
        do_retire(64'h100, 64'h9000_0000, 1'b0, 1'b1);
        checks++;
        if (cpl_o !== 1'b1 || cnt_o !== 32'(exp_cnt) || flush_o !== 1'b1) begin
            failures++;
            $display("FAIL ignore_flush: cpl=%b cnt=%0d flush=%b expected 1 %0d 1", cpl_o, cnt_o, flush_o, exp_cnt);
        end
        tick();
        do_retire(64'h100, 64'h5000, 1'b0, 1'b1);
        checks++;
        if (cpl_o !== 1'b1 || cnt_o !== 32'(exp_cnt) || redirect_vld_o !== 1'b1 || redirect_pc_o !== 64'h300) begin
            failures++;
            $display("FAIL ignore_redirect: cpl=%b cnt=%0d vld=%b pc=%h expected 1 %0d 1 300",
                     cpl_o, cnt_o, redirect_vld_o, redirect_pc_o, exp_cnt);
        end
        finish_redirect();
        do_retire(64'h100, 64'h700, 1'b0, 1'b0);
        do_reset();
        checks++;
        if (redirect_vld_o !== 1'b1 || redirect_pc_o !== RPC || flush_o !== 1'b0 || cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_flush: vld=%b pc=%h flush=%b cnt=%0d expected 1 %h 0 0",
                     redirect_vld_o, redirect_pc_o, flush_o, cnt_o, RPC);
        end
        finish_redirect();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) begin
            do_retire(64'h100, 64'h2000 + 64'(i * 16), 1'b0, 1'b0);
            exp_q.push_back(64'h2000 + 64'(i * 16)); exp_cnt++;
            finish_redirect();
            checks++;
            if (cnt2 !== 2'((exp_cnt > 3) ? 3 : exp_cnt) || cnt_o !== 32'(exp_cnt)) begin
                failures++;
                $display("FAIL sat_%0d: cnt2=%0d cnt=%0d expected %0d %0d",
                         i, cnt2, cnt_o, (exp_cnt > 3) ? 3 : exp_cnt, exp_cnt);
            end
        end
        do_retire(64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 1'b0);
        checks++;
        if (flush_o !== 1'b0 || redirect_vld_o !== 1'b0 || cnt_o !== 32'd5 || cnt2 !== 2'd3) begin
            failures++;
            $display("FAIL pc_wrap: flush=%b vld=%b cnt=%0d cnt2=%0d expected 0 0 5 3",
                     flush_o, redirect_vld_o, cnt_o, cnt2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_priv();
        test_ignored();
        test_saturate();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover: %0d redirects never seen, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
